// File: rtl/btn_conditioner.sv
// N-channel push-button conditioner: synchroniser, counter debounce, press/release
// pulses and optional per-channel auto-repeat, all on the single master clock.
module btn_conditioner #(
   parameter int N_BTN           = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 30000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCW  = $clog2(RMAX + 1);

   localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCW-1:0] RD_LOAD = RCW'(REPEAT_DELAY - 1);
   localparam logic [RCW-1:0] RP_LOAD = RCW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync;
      logic [DCW-1:0]         db_cnt;
      logic                   level;
      logic                   level_nx;
      logic                   accept;
      logic                   press_q;
      logic                   rel_q;
      logic                   rep_q;
      logic [RCW-1:0]         rp_cnt;
      state_t                 state;

      assign sync     = sync_q[SYNC_STAGES-1];
      assign accept   = (sync != level) && (db_cnt == DB_LAST);
      assign level_nx = accept ? sync : level;

      always_ff @(posedge clk) begin
         if (rst) begin
            sync_q  <= '0;
            db_cnt  <= '0;
            level   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
            rp_cnt  <= '0;
            state   <= IDLE;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};

            // Any cycle of agreement clears the count, so glitches never accumulate.
            if (sync == level || accept) db_cnt <= '0;
            else                         db_cnt <= db_cnt + 1'b1;

            level   <= level_nx;
            press_q <= accept & sync;
            rel_q   <= accept & ~sync;
            rep_q   <= 1'b0;

            case (state)
               IDLE: begin
                  // Covers both a fresh press and enabling repeat on an already-held button.
                  if (level_nx && repeat_en[i]) begin
                     state  <= HOLD;
                     rp_cnt <= RD_LOAD;
                  end
               end
               HOLD, REPEAT: begin
                  // Release or disable take priority over a repeat due in the same cycle.
                  if (!level_nx || !repeat_en[i]) begin
                     state <= IDLE;
                  end else if (rp_cnt == '0) begin
                     rep_q  <= 1'b1;
                     state  <= REPEAT;
                     rp_cnt <= RP_LOAD;
                  end else begin
                     rp_cnt <= rp_cnt - 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign btn_level[i]   = level;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = rel_q;
      assign btn_repeat[i]  = rep_q;
   end

endmodule
